// File: rtl/johnson_decoder_monitor.sv
// Johnson code decoder and integrity monitor.
// Samples a WIDTH-bit Johnson code, decodes it to a state index and tracks the step
// direction and the net step count. Illegal codes and skipped states set sticky flags.
// Optional build macro JDEC_INPUT_SYNC_EN puts code and sample through two-flop
// synchronizers before they are evaluated. This adds two cycles of latency.
module johnson_decoder_monitor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] code,
  input  logic             sample,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_skip
);

  typedef enum logic [1:0] {StSync, StLock, StFault} state_e;

  localparam int NStates = 2 * WIDTH;

  logic [WIDTH-1:0] code_eval;
  logic             sample_eval;

`ifdef JDEC_INPUT_SYNC_EN
  logic [WIDTH-1:0] code_s1_q, code_s2_q;
  logic             sample_s1_q, sample_s2_q;

  // Two-flop synchronizers. Each Johnson step changes only one bit, so a code captured
  // mid-change still settles to a neighbouring legal value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_s1_q   <= '0;
      code_s2_q   <= '0;
      sample_s1_q <= 1'b0;
      sample_s2_q <= 1'b0;
    end else begin
      code_s1_q   <= code;
      code_s2_q   <= code_s1_q;
      sample_s1_q <= sample;
      sample_s2_q <= sample_s1_q;
    end
  end

  assign code_eval   = code_s2_q;
  assign sample_eval = sample_s2_q;
`else
  assign code_eval   = code;
  assign sample_eval = sample;
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             err_ill_q, err_ill_d;
  logic             err_skip_q, err_skip_d;

  int               pop;
  int               new_idx_i;
  int               delta;
  logic [WIDTH-1:0] msb_mask, lsb_mask;
  logic             legal;
  logic [IDX_W-1:0] new_idx;

  // Decode the code: legality check, index and step distance from the current index.
  always_comb begin
    pop = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop = pop + int'(code_eval[i]);
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      msb_mask[i] = (i >= int'(WIDTH) - pop);
      lsb_mask[i] = (i < pop);
    end
    // The all-zero code matches both masks.
    legal = (code_eval == msb_mask) || (code_eval == lsb_mask);
    if (code_eval[WIDTH-1] || (pop == 0)) begin
      new_idx_i = pop;
    end else begin
      new_idx_i = NStates - pop;
    end
    new_idx = IDX_W'(new_idx_i);
    delta   = new_idx_i - int'(idx_q);
    if (delta < 0) begin
      delta = delta + NStates;
    end
  end

  // Next-state logic. clr takes priority over sample in the same cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    err_ill_d  = err_ill_q;
    err_skip_d = err_skip_q;
    if (clr) begin
      state_d    = StSync;
      err_ill_d  = 1'b0;
      err_skip_d = 1'b0;
    end else if (sample_eval) begin
      unique case (state_q)
        StSync: begin
          if (legal) begin
            state_d = StLock;
            idx_d   = new_idx;
            pos_d   = '0;
            dir_d   = 1'b0;
          end else begin
            err_ill_d = 1'b1;
          end
        end
        StLock: begin
          if (!legal) begin
            state_d   = StFault;
            err_ill_d = 1'b1;
          end else if (delta == 0) begin
            state_d = StLock;
          end else if (delta == 1) begin
            idx_d = new_idx;
            pos_d = pos_q + CNT_W'(1);
            dir_d = 1'b1;
          end else if (delta == NStates - 1) begin
            idx_d = new_idx;
            pos_d = pos_q - CNT_W'(1);
            dir_d = 1'b0;
          end else begin
            state_d    = StFault;
            err_skip_d = 1'b1;
          end
        end
        StFault: state_d = StFault;
        default: state_d = StSync;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StSync;
      idx_q      <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      err_ill_q  <= 1'b0;
      err_skip_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      err_ill_q  <= err_ill_d;
      err_skip_q <= err_skip_d;
    end
  end

  assign idx         = idx_q;
  assign pos         = pos_q;
  assign dir         = dir_q;
  assign locked      = (state_q == StLock);
  assign err_illegal = err_ill_q;
  assign err_skip    = err_skip_q;

endmodule

// File: doc/johnson_decoder_monitor.md
# johnson_decoder_monitor

Receive-side companion to the team's count-down Johnson counter: samples a WIDTH-bit Johnson code, decodes it to a binary state index, tracks step direction and net step count, and flags illegal codes or skipped states. Sits between a Johnson counter output (local or from an LED/GPIO loopback) and display or self-check logic. Used in lab top levels to verify counter integrity in hardware.

## Interface
- WIDTH, 4: Johnson register width; 2*WIDTH legal states; WIDTH >= 2.
- CNT_W, 8: width of net step counter `pos`.
- IDX_W, $clog2(2*WIDTH): width of `idx` (derived; do not override).

- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- code  in  WIDTH  Johnson code under observation.
- sample  in  1  code is evaluated on this cycle when high.
- clr  in  1  synchronous: clears sticky flags, returns to SYNC.
- idx  out  IDX_W  decoded index of last accepted legal code.
- pos  out  CNT_W  net steps since lock (up +1, down -1, mod 2^CNT_W).
- dir  out  1  1 = last step up, 0 = last step down.
- locked  out  1  high in LOCK state.
- err_illegal  out  1  sticky: non-Johnson code sampled.
- err_skip  out  1  sticky: legal code more than one step from previous.

## Operation
- Code map (W=4): idx 0..7 = 0000,1000,1100,1110,1111,0111,0011,0001. General: legal iff ones are contiguous from MSB or contiguous from LSB, or all zero. idx = popcount if code[W-1]=1 or code=0, else 2W - popcount.
- Up = idx increments (mod 2W); the team's count-down counter therefore shows as down steps.
- delta = (new_idx - idx) mod 2W.
- States: SYNC, LOCK, FAULT.
- SYNC: sample with legal code -> LOCK; idx <= new_idx, pos <= 0, dir <= 0. Illegal -> stay, err_illegal <= 1.
- LOCK, sample:
  - illegal -> FAULT, err_illegal <= 1; idx/pos hold.
  - delta 0 -> no change.
  - delta 1 -> idx update, pos +1, dir <= 1.
  - delta 2W-1 -> idx update, pos -1, dir <= 0.
  - other -> FAULT, err_skip <= 1; idx/pos hold.
- FAULT: ignores sample; exits only on clr.
- clr (any state): -> SYNC, err flags <= 0; idx/pos/dir hold. clr beats sample in the same cycle.
- pos wraps silently at 2^CNT_W boundaries (0 -1 -> all ones).
- Reset values: idx=0, pos=0, dir=0, locked=0, err_illegal=0, err_skip=0, state=SYNC.

## Timing
- All outputs registered; update on the clk edge that samples sample=1 (visible next cycle).
- sample=0: all outputs hold.
- Back-to-back samples every cycle supported; no handshake or backpressure.
- Reset asserted mid-stream clears immediately (asynchronous); first sample after release is treated as SYNC.
- locked falls on the same edge that sets either error flag.

## Configuration
- JDEC_INPUT_SYNC_EN defined: code and sample each pass through a two-flop synchronizer before evaluation; effective latency +2 cycles, alignment of code to sample preserved. Safe because Johnson codes change one bit per step.
- Undefined: code/sample used directly; single-cycle latency as in Timing.

## Test plan
- Reset then sample 0000 -> locked=1, idx=0, pos=0, no errors.
- Lock on 0000, sample 0001,0011,0111,1111 one per cycle -> idx 7,6,5,4; pos=0xFC; dir=0.
- Lock on 0000, sample 1000,1100,1110,1111,0111,0011,0001,0000 -> idx returns to 0, pos=8, dir=1 (wrap-around).
- Lock on 1100, sample 0101 -> err_illegal=1, locked=0, idx=2 held; further samples ignored until clr, then clr -> flags 0, state SYNC.
- Lock on 1000, sample 1110 -> err_skip=1, locked=0; clr and sample 1110 same cycle -> SYNC, sample ignored, flags 0.
- Assert reset mid-sequence with pos=3 -> all outputs 0 immediately; with JDEC_INPUT_SYNC_EN, outputs respond 3 cycles after sample edge.
